// File: rtl/sha256_block_sequencer_if.sv
// Stream and core-bus bundle between the padding front end, the block sequencer
// and the SHA-256 core.
`timescale 1ns/1ps
interface sha256_block_sequencer_if;
  logic        blk_valid;
  logic        blk_ready;
  logic [31:0] blk_word;
  logic        blk_last;

  logic        dig_valid;
  logic        dig_ready;
  logic [31:0] dig_word;
  logic [2:0]  dig_index;

  logic [31:0] core_a;
  logic [31:0] core_d;
  logic [31:0] core_status;
  logic [31:0] core_dout;

  modport master (
    input  blk_valid, blk_word, blk_last, dig_ready, core_status, core_dout,
    output blk_ready, dig_valid, dig_word, dig_index, core_a, core_d
  );

  modport slave (
    output blk_valid, blk_word, blk_last, dig_ready, core_status, core_dout,
    input  blk_ready, dig_valid, dig_word, dig_index, core_a, core_d
  );
endinterface

// File: rtl/sha256_block_sequencer.sv
// Drives the SHA-256 core command bus: loads 16-word blocks, launches compression,
// streams the digest after the final block and re-arms the core between messages.
`timescale 1ns/1ps
module sha256_block_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  sha256_block_sequencer_if.master        bus,
  output logic                            busy,
  output logic                            error
);

  typedef enum logic [3:0] {
    S_ARM, S_IDLE, S_OPEN, S_LOAD, S_COMMIT, S_RUN, S_RDOPEN,
    S_FETCH, S_WAITD, S_CAPT, S_PRESENT, S_CLOSE, S_REARM, S_ERR
  } state_t;

  localparam logic [2:0] CMD_NOP     = 3'b000;
  localparam logic [2:0] CMD_ARM     = 3'b001;
  localparam logic [2:0] CMD_LOAD    = 3'b010;
  localparam logic [2:0] CMD_RDOPEN  = 3'b011;
  localparam logic [2:0] CMD_START   = 3'b100;
  localparam logic [2:0] CMD_RESTART = 3'b111;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic [5:0]    cnt;
  logic [2:0]    idx;
  logic          last;
  logic [TW-1:0] tcnt;

  // Only the completion bit of the core status word carries meaning here.
  logic unused_status;
  assign unused_status = ^bus.core_status[31:1];

  // NOTE: every register in this block uses <= so all of them update together
  // from the values present before the edge; mixing in = would make the result
  // depend on statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= S_ARM;
      cnt           <= '0;
      idx           <= '0;
      last          <= 1'b0;
      tcnt          <= '0;
      busy          <= 1'b0;
      error         <= 1'b0;
      bus.blk_ready <= 1'b0;
      bus.dig_valid <= 1'b0;
      bus.dig_word  <= '0;
      bus.dig_index <= '0;
      bus.core_a    <= '0;
      bus.core_d    <= '0;
    end else begin
      busy <= 1'b1;
      unique case (state)
        S_ARM: begin
          bus.core_a <= {CMD_ARM, 29'b0};
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        S_IDLE: begin
          bus.core_a <= '0;
          busy       <= bus.blk_valid;
          if (bus.blk_valid) state <= S_OPEN;
        end
        S_OPEN: begin
          bus.core_a    <= {CMD_LOAD, 29'b0};
          cnt           <= '0;
          bus.blk_ready <= 1'b1;
          state         <= S_LOAD;
        end
        S_LOAD: begin
          // core_a/core_d are simply held on idle cycles: the core rewrites the
          // same schedule slot with the same word, which is harmless.
          if (bus.blk_valid && bus.blk_ready) begin
            bus.core_a <= {CMD_LOAD, 23'b0, cnt};
            bus.core_d <= bus.blk_word;
            cnt        <= cnt + 6'd1;
            if (cnt == 6'd15) begin
              last          <= bus.blk_last;
              bus.blk_ready <= 1'b0;
              state         <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          bus.core_a <= {CMD_START, 29'b0};
          tcnt       <= '0;
          state      <= S_RUN;
        end
        S_RUN: begin
          bus.core_a <= '0;
          if (bus.core_status[0]) begin
            if (last) begin
              state <= S_RDOPEN;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            error <= 1'b1;
            state <= S_ERR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RDOPEN: begin
          bus.core_a <= {CMD_RDOPEN, 29'b0};
          idx        <= '0;
          state      <= S_FETCH;
        end
        S_FETCH: begin
          bus.core_a <= {CMD_RDOPEN, 26'b0, idx};
          state      <= S_WAITD;
        end
        S_WAITD: state <= S_CAPT;
        S_CAPT: begin
          bus.dig_word  <= bus.core_dout;
          bus.dig_index <= idx;
          bus.dig_valid <= 1'b1;
          state         <= S_PRESENT;
        end
        S_PRESENT: begin
          if (bus.dig_ready) begin
            bus.dig_valid <= 1'b0;
            if (idx == 3'd7) begin
              bus.core_a <= {CMD_NOP, 29'b0};
              state      <= S_CLOSE;
            end else begin
              idx   <= idx + 3'd1;
              state <= S_FETCH;
            end
          end
        end
        S_CLOSE: begin
          bus.core_a <= {CMD_RESTART, 29'b0};
          state      <= S_REARM;
        end
        S_REARM: begin
          // Quiet cycle while the core sits in WAIT reloading H0..H7.
          bus.core_a <= '0;
          state      <= S_ARM;
        end
        S_ERR: begin
          bus.core_a    <= '0;
          bus.blk_ready <= 1'b0;
          bus.dig_valid <= 1'b0;
        end
        default: begin
          error <= 1'b1;
          state <= S_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Self-checking bench: a behavioural SHA-256 core answers the command bus, and a
// message-level SHA-256 model scores every digest word the sequencer presents.
`timescale 1ns/1ps
module tb_sha256_block_sequencer;

  typedef logic [7:0][31:0]  hash_t;
  typedef logic [15:0][31:0] block_t;
  typedef struct { logic [31:0] word; logic [2:0] idx; } dig_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DIG_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic clk_in = 1'b0;
  logic rst_in;
  logic busy;
  logic error;

  sha256_block_sequencer_if bus ();

  sha256_block_sequencer #(.TIMEOUT_CYCLES(15)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.master),
    .busy   (busy),
    .error  (error)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- SHA-256 reference ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic hash_t h_init();
    hash_t h;
    h[0] = 32'h6a09e667; h[1] = 32'hbb67ae85; h[2] = 32'h3c6ef372; h[3] = 32'ha54ff53a;
    h[4] = 32'h510e527f; h[5] = 32'h9b05688c; h[6] = 32'h1f83d9ab; h[7] = 32'h5be0cd19;
    return h;
  endfunction

  function automatic hash_t sha_compress(input hash_t hin, input block_t m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    hash_t hout;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = m[t];
      else w[t] = w[t-16] + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
                + w[t-7] + (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
    end
    a = hin[0]; b = hin[1]; c = hin[2]; d = hin[3];
    e = hin[4]; f = hin[5]; g = hin[6]; hh = hin[7];
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    hout[0] = hin[0] + a; hout[1] = hin[1] + b; hout[2] = hin[2] + c; hout[3] = hin[3] + d;
    hout[4] = hin[4] + e; hout[5] = hin[5] + f; hout[6] = hin[6] + g; hout[7] = hin[7] + hh;
    return hout;
  endfunction

  // ---------------- behavioural SHA core on the command bus ----------------
  typedef enum logic [2:0] {C_WAIT, C_IDLE, C_READ, C_COMP, C_DREAD} core_st_t;
  core_st_t   core_st;
  hash_t      core_h;
  block_t     core_sched;
  int         comp_cnt;
  logic       core_hang = 1'b0;
  logic [2:0] core_cmd;
  assign core_cmd = bus.core_a[31:29];

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      core_st         <= C_WAIT;
      core_h          <= h_init();
      core_sched      <= '0;
      comp_cnt        <= 0;
      bus.core_status <= '0;
      bus.core_dout   <= '0;
    end else begin
      case (core_st)
        C_WAIT: begin
          core_h <= h_init();
          if (core_cmd == 3'b001) core_st <= C_IDLE;
        end
        C_IDLE: begin
          if (core_cmd == 3'b010) begin
            core_st         <= C_READ;
            bus.core_status <= '0;
          end else if (core_cmd == 3'b011) core_st <= C_DREAD;
          else if (core_cmd == 3'b111) core_st <= C_WAIT;
        end
        C_READ: begin
          if (core_cmd == 3'b010) core_sched[bus.core_a[3:0]] <= bus.core_d;
          else if (core_cmd == 3'b100) begin
            core_h   <= sha_compress(core_h, core_sched);
            comp_cnt <= 0;
            core_st  <= C_COMP;
          end
        end
        C_COMP: begin
          if (!core_hang) begin
            if (comp_cnt == 7) begin
              bus.core_status <= 32'h1;
              core_st         <= C_IDLE;
            end else comp_cnt <= comp_cnt + 1;
          end
        end
        C_DREAD: begin
          bus.core_dout <= core_h[bus.core_a[2:0]];
          if (core_cmd == 3'b000) core_st <= C_IDLE;
        end
        default: core_st <= C_WAIT;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  dig_t        exp_q[$];
  logic [31:0] got_q[$];
  logic        stall_armed = 1'b0;

  task automatic expect_msg(input block_t b0, input block_t b1, input int nblk);
    hash_t h;
    h = sha_compress(h_init(), b0);
    if (nblk > 1) h = sha_compress(h, b1);
    for (int i = 0; i < 8; i++) exp_q.push_back('{word: h[i], idx: 3'(i)});
  endtask

  // Every cycle: a presented digest word must match the model's next word;
  // with nothing owed, dig_valid must stay low.
  initial begin
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        if (exp_q.size() == 0) check("dig_valid_idle", 32'(bus.dig_valid), 32'd0);
        else if (bus.dig_valid) begin
          check("dig_word", bus.dig_word, exp_q[0].word);
          check("dig_index", 32'(bus.dig_index), 32'(exp_q[0].idx));
          if (bus.dig_ready) begin
            got_q.push_back(bus.dig_word);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Consumer: stalls 20 cycles on digest word 3 when armed.
  initial begin
    bus.dig_ready = 1'b1;
    forever begin
      @(posedge clk_in); #1;
      if (stall_armed && bus.dig_valid && bus.dig_index == 3'd3) begin
        stall_armed   = 1'b0;
        bus.dig_ready = 1'b0;
        repeat (20) @(posedge clk_in);
        #1 bus.dig_ready = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_word(input logic [31:0] w, input logic l, input int gap);
    int   n;
    logic acc;
    bus.blk_valid = 1'b0;
    repeat (gap) begin @(posedge clk_in); #1; end
    bus.blk_valid = 1'b1;
    bus.blk_word  = w;
    bus.blk_last  = l;
    n = 0; acc = 1'b0;
    while (!acc && n < 300) begin
      @(negedge clk_in);
      acc = bus.blk_ready;
      @(posedge clk_in); #1;
      n++;
    end
    bus.blk_valid = 1'b0;
    if (!acc) check("blk_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_block(input block_t b, input logic last, input int max_gap, input bit spurious);
    for (int i = 0; i < 16; i++)
      send_word(b[i], (i == 15) ? last : (spurious && i == 3),
                (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin @(negedge clk_in); n++; end
    check({name, "_drained"}, 32'(exp_q.size() == 0 && !busy), 32'd1);
    @(negedge clk_in);
    check({name, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic check_digest(input string name, input logic [255:0] lit, input int base);
    for (int i = 0; i < 8; i++)
      check(name, (base + i < got_q.size()) ? got_q[base + i] : 32'hxxxxxxxx, lit[255 - 32*i -: 32]);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_blk_ready"}, 32'(bus.blk_ready), 32'd0);
    check({name, "_dig_valid"}, 32'(bus.dig_valid), 32'd0);
    check({name, "_dig_word"},  bus.dig_word, 32'd0);
    check({name, "_dig_index"}, 32'(bus.dig_index), 32'd0);
    check({name, "_busy"},      32'(busy), 32'd0);
    check({name, "_error"},     32'(error), 32'd0);
    check({name, "_core_a"},    bus.core_a, 32'd0);
    check({name, "_core_d"},    bus.core_d, 32'd0);
  endtask

  initial begin
    #300us;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  block_t abc_b, empty_b, two1_b, two2_b;
  int     n;
  logic   found;

  initial begin
    abc_b   = '0; abc_b[0] = 32'h61626380; abc_b[15] = 32'h00000018;
    empty_b = '0; empty_b[0] = 32'h80000000;
    two1_b[0]  = 32'h61626364; two1_b[1]  = 32'h62636465; two1_b[2]  = 32'h63646566; two1_b[3]  = 32'h64656667;
    two1_b[4]  = 32'h65666768; two1_b[5]  = 32'h66676869; two1_b[6]  = 32'h6768696a; two1_b[7]  = 32'h68696a6b;
    two1_b[8]  = 32'h696a6b6c; two1_b[9]  = 32'h6a6b6c6d; two1_b[10] = 32'h6b6c6d6e; two1_b[11] = 32'h6c6d6e6f;
    two1_b[12] = 32'h6d6e6f70; two1_b[13] = 32'h6e6f7071; two1_b[14] = 32'h80000000; two1_b[15] = 32'h00000000;
    two2_b  = '0; two2_b[15] = 32'h000001c0;

    rst_in = 1'b0;
    bus.blk_valid = 1'b0; bus.blk_word = '0; bus.blk_last = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_reset_outputs("reset");
    @(posedge clk_in); #1 rst_in = 1'b1;
    repeat (3) @(posedge clk_in); #1;

    // "abc", single block
    got_q.delete();
    expect_msg(abc_b, abc_b, 1);
    send_block(abc_b, 1'b1, 0, 1'b0);
    wait_drain("abc");
    check_digest("abc_digest", DIG_ABC, 0);

    // empty string, then "abc" straight behind it: proves the hash re-init
    got_q.delete();
    expect_msg(empty_b, empty_b, 1);
    expect_msg(abc_b, abc_b, 1);
    send_block(empty_b, 1'b1, 0, 1'b0);
    send_block(abc_b, 1'b1, 0, 1'b0);
    wait_drain("empty_abc");
    check_digest("empty_digest", DIG_EMPTY, 0);
    check_digest("abc_after_empty_digest", DIG_ABC, 8);

    // two-block message; blk_last raised on word 3 of block 1 must be ignored
    got_q.delete();
    expect_msg(two1_b, two2_b, 2);
    send_block(two1_b, 1'b0, 0, 1'b1);
    send_block(two2_b, 1'b1, 0, 1'b0);
    wait_drain("two_block");
    check_digest("two_block_digest", DIG_TWO, 0);

    // backpressure on both streams
    got_q.delete();
    expect_msg(abc_b, abc_b, 1);
    stall_armed = 1'b1;
    send_block(abc_b, 1'b1, 3, 1'b0);
    wait_drain("backpressure");
    check_digest("backpressure_digest", DIG_ABC, 0);
    check("stall_consumed", 32'(stall_armed), 32'd0);

    // timeout: the core never completes
    got_q.delete();
    core_hang = 1'b1;
    send_block(abc_b, 1'b1, 0, 1'b0);
    n = 0; found = 1'b0;
    while (!found && n < 50) begin
      @(negedge clk_in);
      found = (bus.core_a[31:29] == 3'b100);
      n++;
    end
    check("run_entry_seen", 32'(found), 32'd1);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk_in);
      if (c == 14) check("error_before_timeout", 32'(error), 32'd0);
      if (c == 15) check("error_at_timeout", 32'(error), 32'd1);
    end
    bus.blk_valid = 1'b1; bus.blk_word = 32'h61626380;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_in);
      check("err_blk_ready", 32'(bus.blk_ready), 32'd0);
      check("err_sticky", 32'(error), 32'd1);
    end
    bus.blk_valid = 1'b0;
    @(posedge clk_in); #1 rst_in = 1'b0;
    core_hang = 1'b0;
    @(negedge clk_in);
    check_reset_outputs("timeout_reset");
    @(posedge clk_in); #1 rst_in = 1'b1;
    repeat (3) @(posedge clk_in); #1;

    // reset in the middle of LOAD at word 9, then a clean "abc"
    got_q.delete();
    for (int i = 0; i < 9; i++) send_word(abc_b[i], 1'b0, 0);
    bus.blk_valid = 1'b1; bus.blk_word = abc_b[9]; bus.blk_last = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    check_reset_outputs("midload_reset");
    bus.blk_valid = 1'b0;
    @(posedge clk_in); #1 rst_in = 1'b1;
    repeat (2) @(posedge clk_in); #1;
    expect_msg(abc_b, abc_b, 1);
    send_block(abc_b, 1'b1, 0, 1'b0);
    wait_drain("after_reset");
    check_digest("after_reset_digest", DIG_ABC, 0);
    check("after_reset_no_partial", 32'(got_q.size()), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
